stage_detranslation: RTL



---
 rtl/stage_detranslation.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/stage_detranslation.sv
// stage_detranslation
// Front stage of the CORDIC rotation pipeline. Holds the active polygon
// (four absolute vertices, reference pixel, form, colour) behind a
// double-buffered host write port. Every cycle it emits each vertex as a
// signed Q10.8 offset from the reference pixel, plus pixel/polygon attributes.
//
// Ports
//   clk, reset                  clock (rising), async active-low reset
//   wr_en/wr_idx/wr_x/wr_y      write one vertex into the shadow set
//   commit, commit_ref_*,       request a shadow->active swap at the next
//   commit_form, commit_color   frame boundary; attributes captured on accept
//   bubble, pixel_x, pixel_y    incoming pipeline slot
//   cordic_v1_x..cordic_v4_y    19-bit signed offsets (offset << 8)
//   out_ref_*, out_form,        active polygon attributes
//   out_color
//   out_pixel_*, out_bubble     one-cycle passthrough
//   busy                        commit pending
//   commit_err                  one-cycle pulse on a rejected write/commit

// Per-vertex offset: d = v - ref in 11-bit signed, scaled to Q10.8.
module vertex_offset (
    input  logic [9:0]  vx,
    input  logic [9:0]  vy,
    input  logic [8:0]  rx,
    input  logic [8:0]  ry,
    input  logic        zero,
    output logic [18:0] off_x,
    output logic [18:0] off_y
);
    logic [10:0] dx, dy;

    // Operand ranges (0..1023 minus 0..511) always fit 11-bit signed.
    assign dx = {1'b0, vx} - {2'b00, rx};
    assign dy = {1'b0, vy} - {2'b00, ry};

    assign off_x = zero ? 19'd0 : {dx, 8'b0};
    assign off_y = zero ? 19'd0 : {dy, 8'b0};
endmodule

module stage_detranslation (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [1:0]  wr_idx,
    input  logic [9:0]  wr_x,
    input  logic [9:0]  wr_y,
    input  logic        commit,
    input  logic [8:0]  commit_ref_x,
    input  logic [8:0]  commit_ref_y,
    input  logic        commit_form,
    input  logic [8:0]  commit_color,
    input  logic        bubble,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    output logic [18:0] cordic_v1_x,
    output logic [18:0] cordic_v1_y,
    output logic [18:0] cordic_v2_x,
    output logic [18:0] cordic_v2_y,
    output logic [18:0] cordic_v3_x,
    output logic [18:0] cordic_v3_y,
    output logic [18:0] cordic_v4_x,
    output logic [18:0] cordic_v4_y,
    output logic [8:0]  out_ref_x,
    output logic [8:0]  out_ref_y,
    output logic        out_form,
    output logic [8:0]  out_color,
    output logic [9:0]  out_pixel_x,
    output logic [9:0]  out_pixel_y,
    output logic        out_bubble,
    output logic        busy,
    output logic        commit_err
);
    localparam int NUM_VERTS = 4;

    typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;
    state_t state, state_nxt;

    // Shadow, pending and active polygon state
    logic [NUM_VERTS-1:0][9:0] sh_x, sh_y, act_x, act_y, nxt_x, nxt_y;
    logic [NUM_VERTS-1:0]      sh_mask, act_mask, nxt_mask, mask_wr;
    logic [8:0]                pend_ref_x, pend_ref_y, pend_color;
    logic                      pend_form;
    logic [8:0]                act_ref_x, act_ref_y, act_color;
    logic                      act_form;
    logic [8:0]                nxt_ref_x, nxt_ref_y, nxt_color;
    logic                      nxt_form;

    logic commit_ok, swap, busy_d, err_d;
    logic [NUM_VERTS-1:0][18:0] off_x, off_y, off_x_q, off_y_q;

    // Mask as it will be after this cycle's write, so a same-cycle write
    // participates in the acceptance check.
    assign mask_wr   = sh_mask | (wr_en ? (4'b0001 << wr_idx) : 4'b0000);
    assign commit_ok = commit && ((mask_wr == 4'b0000) ||
                       (commit_form ? (&mask_wr[2:0]) : (&mask_wr)));
    assign swap      = (state == PENDING) && !bubble &&
                       (pixel_x == 10'd0) && (pixel_y == 10'd0);

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (commit_ok) state_nxt = PENDING;
            PENDING: if (swap)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs (registered below)
    always_comb begin
        busy_d = (state_nxt == PENDING);
        err_d  = 1'b0;
        case (state)
            IDLE:    err_d = commit && !commit_ok;
            PENDING: err_d = wr_en || commit;
            default: err_d = 1'b0;
        endcase
    end

    // Shadow set and pending attributes; writes only land in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_x       <= '0;
            sh_y       <= '0;
            sh_mask    <= '0;
            pend_ref_x <= '0;
            pend_ref_y <= '0;
            pend_form  <= 1'b0;
            pend_color <= '0;
        end else begin
            if (state == IDLE && wr_en) begin
                sh_x[wr_idx] <= wr_x;
                sh_y[wr_idx] <= wr_y;
                sh_mask      <= mask_wr;
            end
            if (state == IDLE && commit_ok) begin
                pend_ref_x <= commit_ref_x;
                pend_ref_y <= commit_ref_y;
                pend_form  <= commit_form;
                pend_color <= commit_color;
            end
            if (swap) sh_mask <= '0;
        end
    end

    // Active set as seen by this cycle's pixel: the boundary pixel already
    // uses the freshly swapped set.
    always_comb begin
        nxt_x     = swap ? sh_x       : act_x;
        nxt_y     = swap ? sh_y       : act_y;
        nxt_mask  = swap ? sh_mask    : act_mask;
        nxt_ref_x = swap ? pend_ref_x : act_ref_x;
        nxt_ref_y = swap ? pend_ref_y : act_ref_y;
        nxt_form  = swap ? pend_form  : act_form;
        nxt_color = swap ? pend_color : act_color;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            act_x     <= '0;
            act_y     <= '0;
            act_mask  <= '0;
            act_ref_x <= '0;
            act_ref_y <= '0;
            act_form  <= 1'b0;
            act_color <= '0;
        end else begin
            act_x     <= nxt_x;
            act_y     <= nxt_y;
            act_mask  <= nxt_mask;
            act_ref_x <= nxt_ref_x;
            act_ref_y <= nxt_ref_y;
            act_form  <= nxt_form;
            act_color <= nxt_color;
        end
    end

    // Offset lanes; v4 is suppressed for triangles, everything for an
    // empty polygon so the back end falls back to its default vertex.
    for (genvar g = 0; g < NUM_VERTS; g++) begin : g_vert
        vertex_offset u_off (
            .vx    (nxt_x[g]),
            .vy    (nxt_y[g]),
            .rx    (nxt_ref_x),
            .ry    (nxt_ref_y),
            .zero  ((nxt_mask == '0) || (g == NUM_VERTS-1 && nxt_form)),
            .off_x (off_x[g]),
            .off_y (off_y[g])
        );
    end

    // Output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            off_x_q     <= '0;
            off_y_q     <= '0;
            out_ref_x   <= '0;
            out_ref_y   <= '0;
            out_form    <= 1'b0;
            out_color   <= '0;
            out_pixel_x <= '0;
            out_pixel_y <= '0;
            out_bubble  <= 1'b0;
            busy        <= 1'b0;
            commit_err  <= 1'b0;
        end else begin
            off_x_q     <= off_x;
            off_y_q     <= off_y;
            out_ref_x   <= nxt_ref_x;
            out_ref_y   <= nxt_ref_y;
            out_form    <= nxt_form;
            out_color   <= nxt_color;
            out_pixel_x <= pixel_x;
            out_pixel_y <= pixel_y;
            out_bubble  <= bubble;
            busy        <= busy_d;
            commit_err  <= err_d;
        end
    end

    assign cordic_v1_x = off_x_q[0];
    assign cordic_v1_y = off_y_q[0];
    assign cordic_v2_x = off_x_q[1];
    assign cordic_v2_y = off_y_q[1];
    assign cordic_v3_x = off_x_q[2];
    assign cordic_v3_y = off_y_q[2];
    assign cordic_v4_x = off_x_q[3];
    assign cordic_v4_y = off_y_q[3];
endmodule
